// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each granted access occupies the memory bus for one cycle and returns a one-cycle ack.
module dm_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] DMAdr,
    output logic              DMWE,
    output logic [DATA_W-1:0] DMDataW,
    input  logic [DATA_W-1:0] DMDataR
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE0,
        SERVE1
    } state_t;

    state_t              state;
    logic                last;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                elig0;
    logic                elig1;
    logic                pick0;
    logic                pick1;

    // A port whose access is on the bus right now still holds req high until its ack;
    // that is the same request, so it must not be granted a second time.
    assign elig0 = req0 & ~ack0 & (state != SERVE0);
    assign elig1 = req1 & ~ack1 & (state != SERVE1);
    assign pick0 = elig0 & (~elig1 | last);
    assign pick1 = elig1 & ~pick0;

    assign DMAdr   = lat_addr;
    assign DMDataW = lat_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            DMWE      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;

            // Complete the access that occupied the bus during the cycle just ending.
            case (state)
                SERVE0: begin
                    ack0 <= 1'b1;
                    last <= 1'b0;
                    if (!lat_we)
                        rdata0 <= DMDataR;
                end
                SERVE1: begin
                    ack1 <= 1'b1;
                    last <= 1'b1;
                    if (!lat_we)
                        rdata1 <= DMDataR;
                end
                default: ;
            endcase

            if (pick0) begin
                state     <= SERVE0;
                lat_we    <= we0;
                lat_addr  <= addr0;
                lat_wdata <= wdata0;
                DMWE      <= we0;
            end else if (pick1) begin
                state     <= SERVE1;
                lat_we    <= we1;
                lat_addr  <= addr1;
                lat_wdata <= wdata1;
                DMWE      <= we1;
            end else begin
                state <= IDLE;
                DMWE  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a small word-addressed memory model.
module tb_dm_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] DMAdr;
    logic        DMWE;
    logic [31:0] DMDataW;
    logic [31:0] DMDataR;

    bit   [31:0] mem [0:63];

    int checks;
    int fails;

    dm_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .ack0    (ack0),
        .ack1    (ack1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .DMAdr   (DMAdr),
        .DMWE    (DMWE),
        .DMDataW (DMDataW),
        .DMDataR (DMDataR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign DMDataR = mem[DMAdr[7:2]];

    always @(posedge clk) begin
        if (DMWE)
            mem[DMAdr[7:2]] <= DMDataW;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (DMWE !== 1'b0) begin fails++; $display("[TB] FAIL reset_dmwe got %0b want 0", DMWE); end
        checks++; if (DMAdr !== 32'h0) begin fails++; $display("[TB] FAIL reset_dmadr got %h want 0", DMAdr); end
        checks++; if (DMDataW !== 32'h0) begin fails++; $display("[TB] FAIL reset_dmdataw got %h want 0", DMDataW); end
        checks++; if ({ack0, ack1} !== 2'b00) begin fails++; $display("[TB] FAIL reset_acks got %b want 00", {ack0, ack1}); end
        checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin fails++; $display("[TB] FAIL reset_rdata got %h/%h want 0/0", rdata0, rdata1); end
        reset = 1'b1;
        tick();
        checks++; if ({DMWE, ack0, ack1} !== 3'b000) begin fails++; $display("[TB] FAIL reset_release got %b want 000", {DMWE, ack0, ack1}); end
    endtask

    task automatic test_single_write();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        tick();
        checks++; if (DMWE !== 1'b1) begin fails++; $display("[TB] FAIL wr_dmwe got %0b want 1", DMWE); end
        checks++; if (DMAdr !== 32'h10) begin fails++; $display("[TB] FAIL wr_dmadr got %h want 10", DMAdr); end
        checks++; if (DMDataW !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL wr_dmdataw got %h want deadbeef", DMDataW); end
        checks++; if (ack0 !== 1'b0) begin fails++; $display("[TB] FAIL wr_ack_early got %0b want 0", ack0); end
        req0 = 1'b0;
        tick();
        checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin fails++; $display("[TB] FAIL wr_ack got %b want 10", {ack0, ack1}); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL wr_mem got %h want deadbeef", mem[4]); end
        checks++; if (DMWE !== 1'b0) begin fails++; $display("[TB] FAIL wr_dmwe_idle got %0b want 0", DMWE); end
        tick();
        checks++; if (ack0 !== 1'b0) begin fails++; $display("[TB] FAIL wr_ack_pulse got %0b want 0", ack0); end
    endtask

    task automatic test_single_read();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10; wdata1 = 32'h0;
        tick();
        checks++; if (DMWE !== 1'b0) begin fails++; $display("[TB] FAIL rd_dmwe got %0b want 0", DMWE); end
        checks++; if (DMAdr !== 32'h10) begin fails++; $display("[TB] FAIL rd_dmadr got %h want 10", DMAdr); end
        req1 = 1'b0;
        tick();
        checks++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin fails++; $display("[TB] FAIL rd_ack got %b want 01", {ack0, ack1}); end
        checks++; if (rdata1 !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL rd_rdata1 got %h want deadbeef", rdata1); end
        checks++; if (DMWE !== 1'b0) begin fails++; $display("[TB] FAIL rd_dmwe_after got %0b want 0", DMWE); end
        tick();
        checks++; if (ack1 !== 1'b0) begin fails++; $display("[TB] FAIL rd_ack_pulse got %0b want 0", ack1); end
    endtask

    task automatic test_tie_after_reset();
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h11111111;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h24; wdata1 = 32'h22222222;
        tick();
        checks++; if (DMAdr !== 32'h20 || DMWE !== 1'b1) begin fails++; $display("[TB] FAIL tie_first got adr %h we %0b want 20/1", DMAdr, DMWE); end
        tick();
        checks++; if (DMAdr !== 32'h24 || DMDataW !== 32'h22222222 || DMWE !== 1'b1) begin fails++; $display("[TB] FAIL tie_second got adr %h data %h we %0b want 24/22222222/1", DMAdr, DMDataW, DMWE); end
        checks++; if ({ack0, ack1} !== 2'b10) begin fails++; $display("[TB] FAIL tie_ack0 got %b want 10", {ack0, ack1}); end
        req0 = 1'b0;
        tick();
        checks++; if ({ack0, ack1} !== 2'b01) begin fails++; $display("[TB] FAIL tie_ack1 got %b want 01", {ack0, ack1}); end
        checks++; if (DMWE !== 1'b0) begin fails++; $display("[TB] FAIL tie_idle_dmwe got %0b want 0", DMWE); end
        checks++; if (mem[8] !== 32'h11111111 || mem[9] !== 32'h22222222) begin fails++; $display("[TB] FAIL tie_mem got %h/%h want 11111111/22222222", mem[8], mem[9]); end
        req1 = 1'b0;
        tick();
        checks++; if ({ack0, ack1} !== 2'b00) begin fails++; $display("[TB] FAIL tie_quiet got %b want 00", {ack0, ack1}); end
    endtask

    task automatic test_fairness();
        int n;
        int cyc;
        logic got;
        n = 0;
        cyc = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h24;
        while (n < 8 && cyc < 60) begin
            tick();
            cyc++;
            checks++; if ((ack0 & ack1) !== 1'b0) begin fails++; $display("[TB] FAIL fair_dual_ack got %b want not 11", {ack0, ack1}); end
            if (ack0 || ack1) begin
                got = ack1;
                checks++; if (got !== n[0]) begin fails++; $display("[TB] FAIL fair_order grant %0d got port %0b want %0b", n, got, n[0]); end
                checks++;
                if (got ? (rdata1 !== 32'h22222222) : (rdata0 !== 32'h11111111)) begin
                    fails++; $display("[TB] FAIL fair_rdata grant %0d got %h/%h", n, rdata0, rdata1);
                end
                n++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checks++; if (n !== 8) begin fails++; $display("[TB] FAIL fair_timeout got %0d grants want 8", n); end
        tick();
    endtask

    task automatic test_reset_mid_write();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'hCAFEF00D;
        tick();
        checks++; if (DMWE !== 1'b1 || DMAdr !== 32'h30) begin fails++; $display("[TB] FAIL mid_serve got we %0b adr %h want 1/30", DMWE, DMAdr); end
        req1 = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (DMWE !== 1'b0) begin fails++; $display("[TB] FAIL mid_dmwe got %0b want 0", DMWE); end
        checks++; if (DMAdr !== 32'h0 || DMDataW !== 32'h0) begin fails++; $display("[TB] FAIL mid_bus got %h/%h want 0/0", DMAdr, DMDataW); end
        checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin fails++; $display("[TB] FAIL mid_rdata got %h/%h want 0/0", rdata0, rdata1); end
        tick();
        checks++; if ({ack0, ack1} !== 2'b00) begin fails++; $display("[TB] FAIL mid_ack got %b want 00", {ack0, ack1}); end
        checks++; if (mem[12] !== 32'h0) begin fails++; $display("[TB] FAIL mid_mem got %h want 0", mem[12]); end
        reset = 1'b1;
        tick();
        checks++; if ({DMWE, ack1} !== 2'b00) begin fails++; $display("[TB] FAIL mid_retry got %b want 00", {DMWE, ack1}); end
        tick();
        checks++; if ({DMWE, ack1} !== 2'b00) begin fails++; $display("[TB] FAIL mid_retry2 got %b want 00", {DMWE, ack1}); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if ({DMWE, ack0, ack1} !== 3'b000) begin fails++; $display("[TB] FAIL idle_cycle %0d got %b want 000", i, {DMWE, ack0, ack1}); end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_tie_after_reset();
        test_fairness();
        test_reset_mid_write();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of the requester and memory address buses.
REQ-002 Parameter DATA_W, default 32, width of the write and read data buses.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req0 / req1  in  1  access request from port 0 (CPU) / port 1 (secondary master).
REQ-006 we0 / we1  in  1  request is a write (1) or a read (0).
REQ-007 addr0 / addr1  in  ADDR_W  byte address of the access.
REQ-008 wdata0 / wdata1  in  DATA_W  write data.
REQ-009 ack0 / ack1  out  1  one-cycle completion pulse, registered.
REQ-010 rdata0 / rdata1  out  DATA_W  read data, registered and valid while the matching ack is high.
REQ-011 DMAdr  out  ADDR_W  data-memory address.
REQ-012 DMWE  out  1  data-memory write enable.
REQ-013 DMDataW  out  DATA_W  data-memory write data.
REQ-014 DMDataR  in  DATA_W  data-memory read data, combinational from DMAdr.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SERVE0, SERVE1.
REQ-016 A request is eligible when reqN=1 and ackN=0 in the same cycle; reqN SHALL be ignored during the cycle its ackN is high.
REQ-017 At each edge in IDLE, SERVE0 or SERVE1, the arbiter SHALL select a next owner among eligible requests:
- only one eligible: that port.
- both eligible: the port not served most recently (round-robin pointer `last`).
- none eligible: next state IDLE.
REQ-018 On selection, the arbiter SHALL latch weN, addrN and wdataN into internal registers and enter SERVEN.
REQ-019 In SERVEN, DMAdr and DMDataW SHALL be driven from the latched registers, and DMWE SHALL equal the latched we.
REQ-020 DMWE SHALL be 0 in IDLE; DMAdr and DMDataW hold their last values there.
REQ-021 At the edge leaving SERVEN:
- rdataN <= DMDataR on a read; rdataN is unchanged on a write.
- ackN <= 1 for exactly one cycle.
- last <= N.
REQ-022 Latency: a request sampled at edge k SHALL be on the memory bus in cycle k..k+1 and its ack SHALL be high in cycle k+1..k+2.
REQ-023 Back-to-back service SHALL run with no idle cycle: SERVE0 may go directly to SERVE1, and SERVE1 directly to SERVE0.
REQ-024 Under continuous dual requests, grants SHALL alternate 0,1,0,1…; no port waits more than one access.
REQ-025 A request withdrawn before it is sampled SHALL have no effect; once latched, the access SHALL complete even if req drops.
REQ-026 ack0 and ack1 SHALL never be high in the same cycle.
REQ-027 At most one access SHALL reach the memory per cycle.

Reset
REQ-028 While reset=0, asynchronously and independent of clk, the block SHALL force:
- state = IDLE;
- DMWE = 0, DMAdr = 0, DMDataW = 0;
- ack0 = ack1 = 0, rdata0 = rdata1 = 0;
- last = 1, so port 0 wins the first tie;
- latched registers cleared.
REQ-029 Reset asserted during SERVEN SHALL abort the access: DMWE drops in the same cycle, no ack is issued, and the request is not retried by the arbiter.
REQ-030 On the first edge after reset deasserts, normal arbitration SHALL resume.

Verification
REQ-031 Single write: req0=1, we0=1, addr0=0x10, wdata0=0xDEADBEEF -> next cycle DMWE=1, DMAdr=0x10; the cycle after, ack0=1 and the memory word at 0x10 is 0xDEADBEEF.
REQ-032 Single read: port 1 reads addr 0x10 after REQ-031 -> ack1=1 with rdata1=0xDEADBEEF; DMWE=0 throughout.
REQ-033 Tie after reset: req0 and req1 rise together -> port 0 served first, port 1 in the next cycle, with no gap; ack0 then ack1 on consecutive cycles.
REQ-034 Fairness: both requests held, each re-asserting after its ack, for 8 accesses -> grant order 0,1,0,1,0,1,0,1; never two acks in one cycle.
REQ-035 Reset mid-write: reset=0 while in SERVE1 with we1=1 -> DMWE=0 immediately, ack1 is never asserted, and all outputs equal their reset values.
REQ-036 Idle: no requests for 10 cycles -> DMWE stays 0 and no ack is asserted.
